// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin contention
// resolution, registered one-hot write enable and zero-register drop counter.
module regfile_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [4:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [4:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [NREG-2:0]   write_en,
    output logic [DATA_W-1:0] write_data,
    output logic [7:0]        zero_drops
);

    localparam logic [4:0] ZERO_ADDR = 5'(NREG - 1);

    typedef enum logic {PRI_A, PRI_B} pri_t;

    pri_t              pri_q, pri_d;
    logic              grant;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-2:0]   en_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pri_q <= PRI_A;
        else        pri_q <= pri_d;
    end

    // The pointer only flips when it actually decided a contended grant.
    always_comb begin
        pri_d   = pri_q;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (reset && !hold) begin
            if (a_valid && b_valid) begin
                if (pri_q == PRI_A) begin
                    a_ready = 1'b1;
                    pri_d   = PRI_B;
                end else begin
                    b_ready = 1'b1;
                    pri_d   = PRI_A;
                end
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    always_comb begin
        grant    = a_ready || b_ready;
        sel_addr = b_ready ? b_addr : a_addr;
        sel_data = b_ready ? b_data : a_data;
        en_d     = '0;
        for (int i = 0; i < NREG - 1; i++) begin
            en_d[i] = (sel_addr == 5'(i));
        end
    end

    // The zero register decodes to no enable bit, so it only bumps the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_en   <= '0;
            write_data <= '0;
            zero_drops <= '0;
        end else begin
            write_en <= grant ? en_d : '0;
            if (grant) begin
                write_data <= sel_data;
            end
            if (grant && sel_addr == ZERO_ADDR && zero_drops != 8'hFF) begin
                zero_drops <= zero_drops + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter plus hand-written
// sequences for zero-register saturation and mid-operation reset.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [63:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [63:0] b_data;
    logic        b_ready;
    logic [30:0] write_en;
    logic [63:0] write_data;
    logic [7:0]  zero_drops;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic        hold;
        logic        a_valid;
        logic [4:0]  a_addr;
        logic [63:0] a_data;
        logic        b_valid;
        logic [4:0]  b_addr;
        logic [63:0] b_data;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic [30:0] exp_we;
        logic [63:0] exp_wd;
        logic [7:0]  exp_zd;
    } vec_t;

    vec_t vecs[19];

    regfile_write_arbiter #(.DATA_W(64), .NREG(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .write_en   (write_en),
        .write_data (write_data),
        .zero_drops (zero_drops)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic h, input logic av, input logic [4:0] aa, input logic [63:0] ad,
        input logic bv, input logic [4:0] ba, input logic [63:0] bd,
        input logic ear, input logic ebr, input logic [30:0] ewe,
        input logic [63:0] ewd, input logic [7:0] ezd);
        vec_t v;
        v.hold = h; v.a_valid = av; v.a_addr = aa; v.a_data = ad;
        v.b_valid = bv; v.b_addr = ba; v.b_data = bd;
        v.exp_a_ready = ear; v.exp_b_ready = ebr;
        v.exp_we = ewe; v.exp_wd = ewd; v.exp_zd = ezd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        hold    = v.hold;
        a_valid = v.a_valid;
        a_addr  = v.a_addr;
        a_data  = v.a_data;
        b_valid = v.b_valid;
        b_addr  = v.b_addr;
        b_data  = v.b_data;
    endtask

    initial begin
        // Hand-computed sequence starting from pointer PRI_A after reset.
        vecs[0]  = mkVec(1'b0, 1'b1, 5'd5,  64'hDEAD_BEEF, 1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 31'h20,         64'hDEAD_BEEF, 8'd0);
        vecs[1]  = mkVec(1'b0, 1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b0, 1'b0, 31'h0,          64'hDEAD_BEEF, 8'd0);
        vecs[2]  = mkVec(1'b0, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b1, 1'b0, 31'h2,          64'h11,        8'd0);
        vecs[3]  = mkVec(1'b0, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b0, 1'b1, 31'h4,          64'h22,        8'd0);
        vecs[4]  = mkVec(1'b0, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b1, 1'b0, 31'h2,          64'h11,        8'd0);
        vecs[5]  = mkVec(1'b0, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b0, 1'b1, 31'h4,          64'h22,        8'd0);
        vecs[6]  = mkVec(1'b1, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b0, 1'b0, 31'h0,          64'h22,        8'd0);
        vecs[7]  = mkVec(1'b1, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b0, 1'b0, 31'h0,          64'h22,        8'd0);
        vecs[8]  = mkVec(1'b1, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b0, 1'b0, 31'h0,          64'h22,        8'd0);
        vecs[9]  = mkVec(1'b0, 1'b1, 5'd1,  64'h11,        1'b1, 5'd2,  64'h22, 1'b1, 1'b0, 31'h2,          64'h11,        8'd0);
        vecs[10] = mkVec(1'b0, 1'b0, 5'd0,  64'h0,         1'b1, 5'd3,  64'h33, 1'b0, 1'b1, 31'h8,          64'h33,        8'd0);
        vecs[11] = mkVec(1'b0, 1'b1, 5'd4,  64'h44,        1'b1, 5'd6,  64'h66, 1'b0, 1'b1, 31'h40,         64'h66,        8'd0);
        vecs[12] = mkVec(1'b0, 1'b1, 5'd31, 64'h66,        1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 31'h0,          64'h66,        8'd1);
        vecs[13] = mkVec(1'b0, 1'b1, 5'd7,  64'h1,         1'b1, 5'd7,  64'h2,  1'b1, 1'b0, 31'h80,         64'h1,         8'd1);
        vecs[14] = mkVec(1'b0, 1'b1, 5'd7,  64'h1,         1'b1, 5'd7,  64'h2,  1'b0, 1'b1, 31'h80,         64'h2,         8'd1);
        vecs[15] = mkVec(1'b1, 1'b1, 5'd8,  64'h8,         1'b0, 5'd0,  64'h0,  1'b0, 1'b0, 31'h0,          64'h2,         8'd1);
        vecs[16] = mkVec(1'b0, 1'b1, 5'd30, 64'h5,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 31'h4000_0000, 64'h5,         8'd1);
        vecs[17] = mkVec(1'b0, 1'b1, 5'd0,  64'h9,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 31'h1,          64'h9,         8'd1);
        vecs[18] = mkVec(1'b0, 1'b0, 5'd0,  64'h0,         1'b1, 5'd31, 64'h9,  1'b0, 1'b1, 31'h0,          64'h9,         8'd2);

        // Reset state, with both requesters valid to show readies stay low.
        reset = 1'b0; hold = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h3;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 64'h4;
        #2;
        checkOutput("reset_a_ready", 64'(a_ready), 64'h0);
        checkOutput("reset_b_ready", 64'(b_ready), 64'h0);
        @(posedge clk); #1;
        checkOutput("reset_write_en", 64'(write_en), 64'h0);
        checkOutput("reset_write_data", write_data, 64'h0);
        checkOutput("reset_zero_drops", 64'(zero_drops), 64'h0);
        a_valid = 1'b0; b_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_a_ready", i), 64'(a_ready), 64'(vecs[i].exp_a_ready));
            checkOutput($sformatf("v%0d_b_ready", i), 64'(b_ready), 64'(vecs[i].exp_b_ready));
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_write_en", i), 64'(write_en), 64'(vecs[i].exp_we));
            checkOutput($sformatf("v%0d_write_data", i), write_data, vecs[i].exp_wd);
            checkOutput($sformatf("v%0d_zero_drops", i), 64'(zero_drops), 64'(vecs[i].exp_zd));
        end

        // Zero-register flood: counter starts at 2 and must stick at 255.
        hold = 1'b0; a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd31; b_data = 64'h9;
        for (int i = 0; i < 300; i++) begin
            #1;
            checkOutput($sformatf("zero_b_ready_%0d", i), 64'(b_ready), 64'h1);
            @(posedge clk); #1;
            checkOutput($sformatf("zero_write_en_%0d", i), 64'(write_en), 64'h0);
            if (i == 252) checkOutput("zero_drops_at_255", 64'(zero_drops), 64'hFF);
        end
        checkOutput("zero_drops_saturated", 64'(zero_drops), 64'hFF);

        // Streaming contention, then reset dropped between edges.
        a_valid = 1'b1; a_addr = 5'd9;  a_data = 64'h99;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 64'hAA;
        #1;
        checkOutput("stream_a_ready", 64'(a_ready), 64'h1);
        @(posedge clk); #1;
        checkOutput("stream_write_en", 64'(write_en), 64'h200);
        checkOutput("stream_b_ready", 64'(b_ready), 64'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_write_en", 64'(write_en), 64'h0);
        checkOutput("midrst_write_data", write_data, 64'h0);
        checkOutput("midrst_zero_drops", 64'(zero_drops), 64'h0);
        checkOutput("midrst_a_ready", 64'(a_ready), 64'h0);
        checkOutput("midrst_b_ready", 64'(b_ready), 64'h0);
        @(posedge clk); #1;
        checkOutput("midrst_no_pulse", 64'(write_en), 64'h0);
        #2 reset = 1'b1;
        #1;
        checkOutput("post_rst_a_ready", 64'(a_ready), 64'h1);
        checkOutput("post_rst_b_ready", 64'(b_ready), 64'h0);
        @(posedge clk); #1;
        checkOutput("post_rst_write_en", 64'(write_en), 64'h200);
        checkOutput("post_rst_write_data", write_data, 64'h99);
        checkOutput("post_rst_next_b_ready", 64'(b_ready), 64'h1);
        @(posedge clk); #1;
        checkOutput("post_rst_b_write_en", 64'(write_en), 64'h400);
        checkOutput("post_rst_b_write_data", write_data, 64'hAA);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning the write data width.
REQ-002 SHALL have parameter NREG, default 32, meaning the architectural register count; register NREG-1 is the hardwired zero register.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = in reset).
REQ-005 SHALL have port hold  input  1  when 1, no new requests are granted.
REQ-006 SHALL have port a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 SHALL have port a_addr  input  5  destination register for A.
REQ-008 SHALL have port a_data  input  DATA_W  write data for A.
REQ-009 SHALL have port a_ready  output  1  A's request is accepted this cycle.
REQ-010 SHALL have ports b_valid, b_addr, b_data and b_ready, with the same widths and meanings as A, for requester B (load unit).
REQ-011 SHALL have port write_en  output  NREG-1  one-hot register-file write enable for registers 30..0.
REQ-012 SHALL have port write_data  output  DATA_W  write data, replicated to all 31 register write inputs at integration.
REQ-013 SHALL have port zero_drops  output  8  saturating count of writes addressed to the zero register.

Function
REQ-014 SHALL accept a request only through a valid&&ready handshake; a_ready and b_ready are combinational from valid, hold and the priority pointer.
REQ-015 SHALL grant at most one requester per cycle; a_ready && b_ready SHALL never both be 1.
REQ-016 SHALL drive both a_ready and b_ready to 0 while hold=1, regardless of valid.
REQ-017 SHALL grant the only valid requester when exactly one of a_valid/b_valid is 1 and hold=0.
REQ-018 SHALL resolve contention with a round-robin priority pointer (states PRI_A, PRI_B), applied when both requesters are valid and hold=0.
REQ-019 SHALL, under contention, grant the pointed requester and move the pointer to the other requester on the same clock edge.
REQ-020 SHALL leave the pointer unchanged on any uncontended grant and on any cycle with hold=1.
REQ-021 SHALL have fixed latency 1: a request accepted at edge N produces write_en = one-hot(addr) and write_data = data during cycle N+1, both registered.
REQ-022 SHALL drive write_en to all zeros in any cycle following an edge with no accepted request; write_data holds its last value.
REQ-023 SHALL accept (ready=1) a request with addr=31, keep write_en all zeros for it, and increment zero_drops, saturating at 255.
REQ-024 SHALL treat a contended cycle where both requesters target the same register exactly like any other contention; the loser's write follows in a later cycle, so last-granted wins.
REQ-025 SHALL allow back-to-back grants on consecutive cycles with no bubble.
REQ-026 SHALL have a requester's payload sampled only on its own handshake cycle; the payload of a requester that is not granted is ignored.

Reset
REQ-027 SHALL, while reset=0, asynchronously force write_en=0, write_data=0, zero_drops=0 and pointer=PRI_A.
REQ-028 SHALL hold a_ready and b_ready at 0 while reset=0.
REQ-029 SHALL discard a request accepted in the cycle when reset asserts mid-operation, so that no write_en pulse appears after reset.
REQ-030 SHALL resume arbitration on the first rising edge after reset deasserts.

Verification
REQ-031 SHALL be verified with a single request: A valid, addr=5, data=64'hDEAD_BEEF, at edge N -> a_ready=1 in that cycle; write_en=31'h20 and write_data=64'hDEAD_BEEF in cycle N+1; write_en=0 in cycle N+2.
REQ-032 SHALL be verified with contention: A and B continuously valid, addrs 1 and 2, for 4 cycles from reset -> grant order A,B,A,B; write_en sequence 31'h2, 31'h4, 31'h2, 31'h4.
REQ-033 SHALL be verified with the zero register: 300 B writes to addr=31 -> b_ready=1 each cycle; write_en stays 0; zero_drops saturates at 8'hFF.
REQ-034 SHALL be verified with hold: hold=1 with A and B valid for 3 cycles -> both readies 0 and write_en 0; on release, grant goes to the pointer state unchanged from before the hold.
REQ-035 SHALL be verified with mid-operation reset: reset=0 asserted asynchronously between edges while A is streaming -> write_en, write_data and zero_drops clear immediately; after release, the first grant goes to A.
REQ-036 SHALL be verified with a same-address collision: A addr=7 data=1 and B addr=7 data=2 contend from PRI_A -> writes occur in the order 1 then 2, with write_en=31'h80 on two consecutive cycles.
